// File: rtl/noc_out_arbiter.sv
// Output-port arbiter: round-robin wormhole selection among the N/S/W/L FWFT FIFO heads with downstream credit check.
// Optional macro NOC_PRESSURE_ARB_EN: IDLE grant favours the candidate with the highest input-FIFO pressure.
module noc_out_arbiter #(
   parameter int DEPTH    = 8,
   parameter int WIDTH    = 3,
   parameter int DATASIZE = 40
) (
   input  logic                fifo_clk,
   input  logic                rst,
   input  logic [DATASIZE-1:0] N_data_in,
   input  logic [DATASIZE-1:0] S_data_in,
   input  logic [DATASIZE-1:0] W_data_in,
   input  logic [DATASIZE-1:0] L_data_in,
   input  logic                N_valid_in,
   input  logic                S_valid_in,
   input  logic                W_valid_in,
   input  logic                L_valid_in,
   input  logic                N_req_in,
   input  logic                S_req_in,
   input  logic                W_req_in,
   input  logic                L_req_in,
   input  logic [WIDTH:0]      N_pressure_in,
   input  logic [WIDTH:0]      S_pressure_in,
   input  logic [WIDTH:0]      W_pressure_in,
   input  logic [WIDTH:0]      L_pressure_in,
   output logic                fifo_ready_N,
   output logic                fifo_ready_S,
   output logic                fifo_ready_W,
   output logic                fifo_ready_L,
   output logic [DATASIZE-1:0] out_data,
   output logic                out_valid,
   input  logic [WIDTH:0]      down_pressure_in,
   output logic [1:0]          lock_owner_out,
   output logic                locked_out
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;
   localparam logic [1:0] TYPE_HEAD = 2'b10;
   localparam logic [WIDTH+1:0] DEPTH_W = (WIDTH+2)'(DEPTH);

   logic [0:0]          state_q, state_d;
   logic [1:0]          rr_ptr_q, rr_ptr_d;
   logic [1:0]          owner_q, owner_d;
   logic [DATASIZE-1:0] out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d;

   logic [DATASIZE-1:0] data_s [4];
   logic [3:0]          valid_s;
   logic [3:0]          req_s;
   logic [3:0]          cand_s;
   logic [1:0]          grant_s;
   logic                grant_found_s;
   logic [1:0]          sel_s;
   logic [1:0]          sel_type_s;
   logic                issue_s;
   logic                issue_ok_s;
   logic [3:0]          ready_s;
   logic [WIDTH+1:0]    credit_sum_s;
   logic                credit_ok_s;

   assign data_s[0] = N_data_in;
   assign data_s[1] = S_data_in;
   assign data_s[2] = W_data_in;
   assign data_s[3] = L_data_in;
   assign valid_s   = {L_valid_in, W_valid_in, S_valid_in, N_valid_in};
   assign req_s     = {L_req_in, W_req_in, S_req_in, N_req_in};

   // The out_valid term accounts for the flit written last cycle but not yet counted downstream.
   assign credit_sum_s = {1'b0, down_pressure_in} + {{(WIDTH+1){1'b0}}, out_valid_q};
   assign credit_ok_s  = (credit_sum_s < DEPTH_W);

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         cand_s[i] = valid_s[i] & req_s[i] & data_s[i][DATASIZE-1];
      end
   end

`ifdef NOC_PRESSURE_ARB_EN
   logic [WIDTH:0] pres_s [4];
   logic [WIDTH:0] best_pres_s;

   assign pres_s[0] = N_pressure_in;
   assign pres_s[1] = S_pressure_in;
   assign pres_s[2] = W_pressure_in;
   assign pres_s[3] = L_pressure_in;

   // Strict greater-than keeps the earliest candidate in round-robin order on ties.
   always_comb begin
      grant_s       = 2'd0;
      grant_found_s = 1'b0;
      best_pres_s   = '0;
      for (int k = 0; k < 4; k++) begin
         if (cand_s[rr_ptr_q + k[1:0]] &&
             (!grant_found_s || (pres_s[rr_ptr_q + k[1:0]] > best_pres_s))) begin
            grant_s       = rr_ptr_q + k[1:0];
            best_pres_s   = pres_s[rr_ptr_q + k[1:0]];
            grant_found_s = 1'b1;
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end
`else
   logic unused_pressure_s;
   assign unused_pressure_s = ^{N_pressure_in, S_pressure_in, W_pressure_in, L_pressure_in};

   always_comb begin
      grant_s       = 2'd0;
      grant_found_s = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (!grant_found_s && cand_s[rr_ptr_q + k[1:0]]) begin
            grant_s       = rr_ptr_q + k[1:0];
            grant_found_s = 1'b1;
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end
`endif

   always_comb begin
      sel_s   = grant_s;
      issue_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            sel_s   = grant_s;
            issue_s = grant_found_s & credit_ok_s;
         end
         ST_LOCKED: begin
            sel_s   = owner_q;
            issue_s = valid_s[owner_q] & credit_ok_s;
         end
         default: begin
            sel_s   = grant_s;
            issue_s = 1'b0;
         end
      endcase
   end

   assign issue_ok_s   = issue_s & ~rst;
   assign sel_type_s   = data_s[sel_s][DATASIZE-1 -: 2];
   assign ready_s      = issue_ok_s ? (4'b0001 << sel_s) : 4'b0000;
   assign fifo_ready_N = ready_s[0];
   assign fifo_ready_S = ready_s[1];
   assign fifo_ready_W = ready_s[2];
   assign fifo_ready_L = ready_s[3];

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      out_valid_d = issue_ok_s;
      out_data_d  = issue_ok_s ? data_s[sel_s] : out_data_q;
      if (issue_ok_s) begin
         case (state_q)
            ST_IDLE: begin
               rr_ptr_d = sel_s + 2'd1;
               if (sel_type_s == TYPE_HEAD) begin
                  state_d = ST_LOCKED;
                  owner_d = sel_s;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_LOCKED: begin
               // Tail (01) and single (11) both close the packet.
               if (sel_type_s[0]) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_LOCKED;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   always_ff @(posedge fifo_clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= 2'd0;
         owner_q     <= 2'd0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data       = out_data_q;
   assign out_valid      = out_valid_q;
   assign lock_owner_out = owner_q;
   assign locked_out     = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Directed self-checking bench for noc_out_arbiter; input FIFOs are modelled as simple queues driving FWFT heads.
module tb_noc_out_arbiter;

   localparam int DEPTH = 8;
   localparam int WIDTH = 3;
   localparam int DS    = 40;

   logic          fifo_clk = 1'b0;
   logic          rst = 1'b1;
   logic [DS-1:0] N_data_in, S_data_in, W_data_in, L_data_in;
   logic          N_valid_in, S_valid_in, W_valid_in, L_valid_in;
   logic          N_req_in, S_req_in, W_req_in, L_req_in;
   logic [WIDTH:0] N_pressure_in = 4'd0, S_pressure_in = 4'd0, W_pressure_in = 4'd0, L_pressure_in = 4'd0;
   logic          fifo_ready_N, fifo_ready_S, fifo_ready_W, fifo_ready_L;
   logic [DS-1:0] out_data;
   logic          out_valid;
   logic [WIDTH:0] down_pressure_in = 4'd0;
   logic [1:0]    lock_owner_out;
   logic          locked_out;

   logic [DS-1:0] qn[$], qs[$], qw[$], ql[$];
   logic [3:0]    req_en = 4'b1111;
   int            n_checks = 0;
   int            n_fail = 0;

   noc_out_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DATASIZE(DS)) dut (
      .fifo_clk(fifo_clk), .rst(rst),
      .N_data_in(N_data_in), .S_data_in(S_data_in), .W_data_in(W_data_in), .L_data_in(L_data_in),
      .N_valid_in(N_valid_in), .S_valid_in(S_valid_in), .W_valid_in(W_valid_in), .L_valid_in(L_valid_in),
      .N_req_in(N_req_in), .S_req_in(S_req_in), .W_req_in(W_req_in), .L_req_in(L_req_in),
      .N_pressure_in(N_pressure_in), .S_pressure_in(S_pressure_in),
      .W_pressure_in(W_pressure_in), .L_pressure_in(L_pressure_in),
      .fifo_ready_N(fifo_ready_N), .fifo_ready_S(fifo_ready_S),
      .fifo_ready_W(fifo_ready_W), .fifo_ready_L(fifo_ready_L),
      .out_data(out_data), .out_valid(out_valid), .down_pressure_in(down_pressure_in),
      .lock_owner_out(lock_owner_out), .locked_out(locked_out)
   );

   always #5 fifo_clk = ~fifo_clk;

   function automatic logic [DS-1:0] flit(input logic [1:0] t, input logic [7:0] payload);
      flit = {t, 30'd0, payload};
   endfunction

   function automatic logic [3:0] rdy();
      rdy = {fifo_ready_L, fifo_ready_W, fifo_ready_S, fifo_ready_N};
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_heads();
      N_valid_in = (qn.size() > 0); N_data_in = N_valid_in ? qn[0] : '0; N_req_in = req_en[0] & N_valid_in;
      S_valid_in = (qs.size() > 0); S_data_in = S_valid_in ? qs[0] : '0; S_req_in = req_en[1] & S_valid_in;
      W_valid_in = (qw.size() > 0); W_data_in = W_valid_in ? qw[0] : '0; W_req_in = req_en[2] & W_valid_in;
      L_valid_in = (ql.size() > 0); L_data_in = L_valid_in ? ql[0] : '0; L_req_in = req_en[3] & L_valid_in;
   endtask

   // One clock: pops follow the ready strobes seen just before the edge.
   task automatic tick();
      logic [3:0] p;
      p = rdy();
      @(posedge fifo_clk);
      #1;
      if (p[0] && qn.size() > 0) void'(qn.pop_front());
      if (p[1] && qs.size() > 0) void'(qs.pop_front());
      if (p[2] && qw.size() > 0) void'(qw.pop_front());
      if (p[3] && ql.size() > 0) void'(ql.pop_front());
      drive_heads();
      #1;
   endtask

   task automatic do_reset();
      qn.delete(); qs.delete(); qw.delete(); ql.delete();
      rst = 1'b1;
      drive_heads();
      tick();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      drive_heads();
      tick();

      // Reset holds off a pending N request
      qn.push_back(flit(2'b11, 8'h11));
      drive_heads(); #1;
      check_eq("rst_ready", rdy(), 4'b0000);
      tick();
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_out_data", out_data, 40'd0);
      check_eq("rst_locked", locked_out, 1'b0);
      check_eq("rst_owner", lock_owner_out, 2'd0);
      check_eq("rst_ready_hold", rdy(), 4'b0000);
      rst = 1'b0; #1;
      check_eq("rst_first_pop", rdy(), 4'b0001);
      tick();
      check_eq("rst_first_valid", out_valid, 1'b1);
      check_eq("rst_first_data", out_data, flit(2'b11, 8'h11));
      tick();
      check_eq("rst_valid_drop", out_valid, 1'b0);

      // Single flits from N and W, then rr_ptr=3 favours L over N
      do_reset();
      qn.push_back(flit(2'b11, 8'h21));
      qw.push_back(flit(2'b11, 8'h22));
      drive_heads(); #1;
      check_eq("sgl_c1_ready", rdy(), 4'b0001);
      tick();
      check_eq("sgl_c2_ready", rdy(), 4'b0100);
      check_eq("sgl_c2_valid", out_valid, 1'b1);
      check_eq("sgl_c2_data", out_data, flit(2'b11, 8'h21));
      check_eq("sgl_c2_locked", locked_out, 1'b0);
      tick();
      check_eq("sgl_c3_valid", out_valid, 1'b1);
      check_eq("sgl_c3_data", out_data, flit(2'b11, 8'h22));
      check_eq("sgl_c3_ready", rdy(), 4'b0000);
      tick();
      check_eq("sgl_c4_valid", out_valid, 1'b0);
      check_eq("sgl_c4_data_hold", out_data, flit(2'b11, 8'h22));
      qn.push_back(flit(2'b11, 8'h23));
      ql.push_back(flit(2'b11, 8'h24));
      drive_heads(); #1;
      check_eq("rr3_L_first", rdy(), 4'b1000);
      tick();
      check_eq("rr3_N_next", rdy(), 4'b0001);
      check_eq("rr3_L_data", out_data, flit(2'b11, 8'h24));

      // Wormhole: S packet holds the port while L waits
      do_reset();
      qs.push_back(flit(2'b10, 8'h31));
      qs.push_back(flit(2'b00, 8'h32));
      qs.push_back(flit(2'b00, 8'h33));
      qs.push_back(flit(2'b01, 8'h34));
      ql.push_back(flit(2'b11, 8'h35));
      drive_heads(); #1;
      check_eq("wh_c1_ready", rdy(), 4'b0010);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("wh_ready", rdy(), 4'b0010);
         check_eq("wh_locked", locked_out, 1'b1);
         check_eq("wh_owner", lock_owner_out, 2'd1);
         check_eq("wh_data", out_data[7:0], 8'h31 + 8'(i));
      end
      tick();
      check_eq("wh_tail_data", out_data, flit(2'b01, 8'h34));
      check_eq("wh_tail_unlock", locked_out, 1'b0);
      check_eq("wh_L_pop", rdy(), 4'b1000);
      tick();
      check_eq("wh_L_data", out_data, flit(2'b11, 8'h35));
      check_eq("wh_L_valid", out_valid, 1'b1);

      // Credit: count 7 plus the in-flight flit blocks; count 8 blocks
      do_reset();
      down_pressure_in = 4'd7;
      qn.push_back(flit(2'b11, 8'h41));
      qn.push_back(flit(2'b11, 8'h42));
      drive_heads(); #1;
      check_eq("cr_p7_v0_pop", rdy(), 4'b0001);
      tick();
      check_eq("cr_p7_v1_valid", out_valid, 1'b1);
      check_eq("cr_p7_v1_block", rdy(), 4'b0000);
      tick();
      check_eq("cr_p7_v0_again", rdy(), 4'b0001);
      down_pressure_in = 4'd8; #1;
      check_eq("cr_p8_block", rdy(), 4'b0000);
      tick();
      check_eq("cr_p8_no_valid", out_valid, 1'b0);
      check_eq("cr_p8_still_block", rdy(), 4'b0000);
      down_pressure_in = 4'd0; #1;
      check_eq("cr_p0_pop", rdy(), 4'b0001);
      tick();
      check_eq("cr_p0_data", out_data, flit(2'b11, 8'h42));

      // Owner N runs empty mid-packet; W must wait
      do_reset();
      qn.push_back(flit(2'b10, 8'h51));
      qw.push_back(flit(2'b11, 8'h52));
      drive_heads(); #1;
      check_eq("me_head_pop", rdy(), 4'b0001);
      tick();
      check_eq("me_locked", locked_out, 1'b1);
      check_eq("me_owner", lock_owner_out, 2'd0);
      for (int i = 0; i < 5; i++) begin
         check_eq("me_stall", rdy(), 4'b0000);
         tick();
      end
      check_eq("me_still_locked", locked_out, 1'b1);
      qn.push_back(flit(2'b01, 8'h53));
      drive_heads(); #1;
      check_eq("me_tail_pop", rdy(), 4'b0001);
      tick();
      check_eq("me_tail_data", out_data, flit(2'b01, 8'h53));
      check_eq("me_W_pop", rdy(), 4'b0100);
      tick();
      check_eq("me_W_data", out_data, flit(2'b11, 8'h52));

      // Pressure-aware grant versus plain round-robin
      do_reset();
      N_pressure_in = 4'd2;
      L_pressure_in = 4'd6;
      qn.push_back(flit(2'b11, 8'h61));
      ql.push_back(flit(2'b11, 8'h62));
      drive_heads(); #1;
`ifdef NOC_PRESSURE_ARB_EN
      check_eq("pr_first", rdy(), 4'b1000);
`else
      check_eq("pr_first", rdy(), 4'b0001);
`endif
      tick();
`ifdef NOC_PRESSURE_ARB_EN
      check_eq("pr_second", rdy(), 4'b0001);
`else
      check_eq("pr_second", rdy(), 4'b1000);
`endif
      tick();
      tick();
      check_eq("pr_drain", rdy(), 4'b0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/noc_out_arbiter.md
Name: noc_out_arbiter

Overview:
- Reader side of the per-router input FIFO bank (N, S, W, L first-word-fall-through FIFOs).
- One instance per router output port. It selects among the four input FIFO heads that request this port, using round-robin wormhole arbitration.
- Pops the granted flit and drives it into the downstream neighbour's input FIFO.
- Never overflows the downstream FIFO: admission uses the neighbour's pressure count plus the flit in flight.

Parameters:
- DEPTH, 8, downstream FIFO depth in flits.
- WIDTH, 3, log2(DEPTH); pressure ports are WIDTH+1 bits.
- DATASIZE, 40, flit width; bits [DATASIZE-1:DATASIZE-2] are the flit type: 2'b10 head, 2'b00 body, 2'b01 tail, 2'b11 single.

Ports:
- fifo_clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- N_data_in / S_data_in / W_data_in / L_data_in  in  DATASIZE  head flit of each input FIFO.
- N_valid_in / S_valid_in / W_valid_in / L_valid_in  in  1  FIFO non-empty.
- N_req_in / S_req_in / W_req_in / L_req_in  in  1  route logic: the current head flit targets this output.
- N_pressure_in / S_pressure_in / W_pressure_in / L_pressure_in  in  WIDTH+1  input FIFO occupancy; used only with the optional feature.
- fifo_ready_N / fifo_ready_S / fifo_ready_W / fifo_ready_L  out  1  pop strobe to each input FIFO; combinational.
- out_data  out  DATASIZE  flit to the downstream FIFO wdata; registered.
- out_valid  out  1  downstream write enable; registered; high exactly one cycle per flit.
- down_pressure_in  in  WIDTH+1  downstream FIFO count.
- lock_owner_out  out  2  current owner index: 0=N, 1=S, 2=W, 3=L.
- locked_out  out  1  high while a packet holds the port.

Behaviour:
- Reset (sync, rst=1 at an edge):
  - State goes to IDLE; rr_ptr = 0 (N); out_valid = 0; out_data = 0; lock_owner_out = 0; locked_out = 0.
  - All fifo_ready_* are 0 while rst is high.
  - A packet in progress is abandoned; there is no flush.
- Credit check: credit_ok = (down_pressure_in + out_valid) < DEPTH, computed WIDTH+2 bits wide. The out_valid term covers the flit written last cycle that is not yet reflected in the count.
- Input FIFOs are first-word-fall-through: X_data_in is valid while X_valid_in=1. fifo_ready_X=1 at an edge consumes that flit.
- Issue in a cycle: exactly one fifo_ready_X is high, with X_valid_in=1. At the next edge, out_data <= X_data_in and out_valid <= 1. Otherwise out_valid <= 0 and out_data holds.
- Latency: one cycle from pop to out_valid.
- Sustained throughput: one flit per cycle while credit_ok holds.
- IDLE state:
  - Candidates are inputs with valid=1, req=1 and type head or single.
  - Grant goes to the first candidate at or after rr_ptr, in the order N, S, W, L with wrap from 3 to 0.
  - The grant issues only if credit_ok; otherwise nothing issues and the grant is recomputed next cycle.
  - On issue, rr_ptr <= grant+1 mod 4.
  - On issue of a head flit: go to LOCKED with owner = grant.
  - On issue of a single flit: stay in IDLE.
  - A requesting input whose head flit is body or tail is ignored.
- LOCKED state:
  - Only the owner can issue; req is ignored.
  - The owner issues when owner valid=1 and credit_ok.
  - On issue of a tail or single flit: return to IDLE at the same edge.
  - On issue of a head or body flit: stay LOCKED.
  - An owner FIFO that is empty mid-packet stalls the port; other inputs wait (wormhole).
- Simultaneous events:
  - Tail issue and a new head request in the same cycle: the new head is arbitrated the following cycle, from IDLE.
  - A FIFO pop and the upstream write into the same FIFO are the FIFO's concern; this block is unaffected.
- locked_out = (state==LOCKED). lock_owner_out holds the last owner in IDLE.

Optional Feature:
- Macro NOC_PRESSURE_ARB_EN.
- Defined: IDLE arbitration grants the candidate with the largest X_pressure_in. Ties are broken by round-robin order from rr_ptr, and rr_ptr is updated as above.
- Not defined: pure round-robin; the X_pressure_in ports are present but unused.

Test Plan:
- Reset: rst=1 with N_valid_in=1 and N_req_in=1 -> all fifo_ready_*=0, out_valid=0, locked_out=0. First issue occurs in the cycle after rst drops.
- Single flits: N and W each present a single flit (type 2'b11) with req=1, down_pressure_in=0 -> N is popped in cycle 1 and W in cycle 2. out_valid is high in cycles 2 and 3; rr_ptr=3 afterwards.
- Wormhole: S sends head, body, body, tail while L requests continuously -> the four S flits appear on consecutive cycles and locked_out=1 throughout. The first L flit pops the cycle after the tail pops.
- Credit: down_pressure_in=7 with out_valid=1 -> no pop. Pressure=7 with out_valid=0 -> one pop. Pressure=8 -> no pop.
- Mid-packet empty: owner N empties after the head, W requests -> no pops for 5 cycles. N resumes with tail -> the tail is forwarded, then W is granted.
- NOC_PRESSURE_ARB_EN: N and L request with N_pressure_in=2 and L_pressure_in=6, rr_ptr=0 -> L is granted first. Without the macro -> N is granted first.
